// File: rtl/msg_pkg.sv
// Shared types and widths for the message scroller.
package msg_pkg;

    localparam int unsigned CHAR_W     = 5;
    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned INDEX_W    = 4;
    localparam int unsigned DIGITS_W   = CHAR_W * NUM_DIGITS;

    typedef enum logic [1:0] {
        STOP   = 2'd0,
        FILL   = 2'd1,
        SCROLL = 2'd2
    } state_t;

endpackage

// File: rtl/scroll_tick.sv
// Free-running step timer: tick fires on the last count of each TICK_DIV period.
module scroll_tick #(
    parameter int unsigned TICK_DIV = 12000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned     CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/message_scroller.sv
// Three-character message scroller: fills from ROM index 0, then shifts one character per tick.
// Optional MSG_SCROLL_REVERSE_EN adds a dir input for reverse scrolling.
module message_scroller
    import msg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12000000,
    parameter int unsigned MSG_LEN  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
`ifdef MSG_SCROLL_REVERSE_EN
    input  logic                dir,
`endif
    input  logic [CHAR_W-1:0]   value,
    output logic [INDEX_W-1:0]  index,
    output logic [DIGITS_W-1:0] digits,
    output logic                busy,
    output logic                wrap
);

    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(MSG_LEN - 1);
    localparam logic [INDEX_W-1:0] FILL_END = INDEX_W'(NUM_DIGITS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [INDEX_W-1:0]    r_index;
    logic [INDEX_W-1:0]    w_index_nxt;
    logic [DIGITS_W-1:0]   r_digits;
    logic [DIGITS_W-1:0]   w_digits_nxt;
    logic                  r_busy;
    logic                  r_wrap;
    logic                  w_wrap_nxt;
    logic                  w_clear;
    logic                  w_tick_en;
    logic                  w_tick;

    assign w_tick_en = (r_state == SCROLL) && run;

    scroll_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .enable (w_tick_en),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping run always wins over a coincident fill shift or tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_digits_nxt = r_digits;
        w_wrap_nxt   = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            STOP: begin
                if (run) begin
                    w_state_nxt = FILL;
                    w_index_nxt = '0;
                    w_clear     = 1'b1;
                end
            end
            FILL: begin
                if (!run) begin
                    w_state_nxt = STOP;
                end else begin
                    w_digits_nxt = {r_digits[DIGITS_W-CHAR_W-1:0], value};
                    w_index_nxt  = r_index + INDEX_W'(1);
                    if (r_index == FILL_END) begin
                        w_state_nxt = SCROLL;
                    end
                end
            end
            SCROLL: begin
                if (!run) begin
                    w_state_nxt = STOP;
                end else if (w_tick) begin
`ifdef MSG_SCROLL_REVERSE_EN
                    if (dir) begin
                        w_digits_nxt = {value, r_digits[DIGITS_W-1:CHAR_W]};
                        w_index_nxt  = (r_index == '0) ? LAST_IDX : r_index - INDEX_W'(1);
                        w_wrap_nxt   = (r_index == '0);
                    end else
`endif
                    begin
                        w_digits_nxt = {r_digits[DIGITS_W-CHAR_W-1:0], value};
                        w_index_nxt  = (r_index == LAST_IDX) ? '0 : r_index + INDEX_W'(1);
                        w_wrap_nxt   = (r_index == LAST_IDX);
                    end
                end
            end
            default: begin
                w_state_nxt = STOP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index  <= '0;
            r_digits <= '0;
            r_busy   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_index  <= w_index_nxt;
            r_digits <= w_digits_nxt;
            r_busy   <= (w_state_nxt != STOP);
            r_wrap   <= w_wrap_nxt;
        end
    end

    assign index  = r_index;
    assign digits = r_digits;
    assign busy   = r_busy;
    assign wrap   = r_wrap;

endmodule
